// File: rtl/weight_pattern_gen.sv
// weight_pattern_gen: emits every WIDTH-bit vector of weight ID % 10 in ascending order over valid/ready.
// Defining WPG_SELFCHECK_EN adds a sticky weight/ordering checker driving err; otherwise err is 0.
module weight_pattern_gen #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      ID,
    output logic [WIDTH-1:0] M,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [6:0]       n_sent,
    output logic             err
);
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] m_r, m_nxt_s;
    logic [WIDTH-1:0] last_r, last_nxt_s;
    logic [3:0]       k_start_s;
    logic             m_valid_r, m_valid_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic [6:0]       n_sent_r, n_sent_nxt_s;
    logic             fire_s, at_last_s;

    function automatic logic [WIDTH-1:0] low_ones(input logic [3:0] k);
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i] = (i < int'(k));
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] high_ones(input logic [3:0] k);
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i] = (i >= WIDTH - int'(k));
        return v;
    endfunction

    // Gosper's successor one bit wider than M; c is one-hot, so dividing by it is a shift by its index.
    function automatic logic [WIDTH-1:0] gosper_next(input logic [WIDTH-1:0] m);
        logic [WIDTH:0] mw, c, r, x;
        int             tz;
        mw = {1'b0, m};
        c  = mw & (-mw);
        r  = mw + c;
        tz = 0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (c[i]) tz = i;
        end
        x = ((r ^ mw) >> 2) >> tz;
        x = x | r;
        return x[WIDTH-1:0];
    endfunction

    assign k_start_s = 4'(ID % 32'd10);
    assign fire_s    = m_valid_r & m_ready;
    assign at_last_s = (m_r == last_r);

    assign M       = m_r;
    assign m_valid = m_valid_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign n_sent  = n_sent_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (fire_s && at_last_s) state_nxt_s = IDLE;
                else                     state_nxt_s = RUN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched final pattern.
    always_comb begin
        m_nxt_s       = m_r;
        last_nxt_s    = last_r;
        m_valid_nxt_s = m_valid_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        n_sent_nxt_s  = n_sent_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    m_nxt_s       = low_ones(k_start_s);
                    last_nxt_s    = high_ones(k_start_s);
                    n_sent_nxt_s  = 7'd0;
                    m_valid_nxt_s = 1'b1;
                    busy_nxt_s    = 1'b1;
                end else begin
                    m_valid_nxt_s = 1'b0;
                    busy_nxt_s    = 1'b0;
                end
            end
            RUN: begin
                if (fire_s) begin
                    n_sent_nxt_s = n_sent_r + 7'd1;
                    if (at_last_s) begin
                        m_valid_nxt_s = 1'b0;
                        busy_nxt_s    = 1'b0;
                        done_nxt_s    = 1'b1;
                    end else begin
                        m_nxt_s = gosper_next(m_r);
                    end
                end else begin
                    m_nxt_s = m_r;
                end
            end
            default: begin
                m_valid_nxt_s = 1'b0;
                busy_nxt_s    = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_r       <= {WIDTH{1'b0}};
            last_r    <= {WIDTH{1'b0}};
            m_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            n_sent_r  <= 7'd0;
        end else begin
            m_r       <= m_nxt_s;
            last_r    <= last_nxt_s;
            m_valid_r <= m_valid_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            n_sent_r  <= n_sent_nxt_s;
        end
    end

`ifdef WPG_SELFCHECK_EN
    logic [3:0]       k_r;
    logic [WIDTH-1:0] prev_r;
    logic             have_prev_r;
    logic             err_r;

    function automatic logic [3:0] popcount(input logic [WIDTH-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < WIDTH; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    // Latch the target weight; flag any accepted beat of the wrong weight or not above its predecessor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_r         <= 4'd0;
            prev_r      <= {WIDTH{1'b0}};
            have_prev_r <= 1'b0;
            err_r       <= 1'b0;
        end else if (state_r == IDLE && start) begin
            k_r         <= k_start_s;
            have_prev_r <= 1'b0;
        end else if (fire_s) begin
            if (popcount(m_r) != k_r || (have_prev_r && m_r <= prev_r)) err_r <= 1'b1;
            prev_r      <= m_r;
            have_prev_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule
